// File: rtl/rv32_pkg.sv
// Shared definitions for the rv32 register file / PC block: defaults, PC step sizes
// and the clear-sequencer state encoding.
package rv32_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP_16       = 2;
    localparam int unsigned PC_STEP_32       = 4;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    // PC advance for a compressed (16-bit) or full (32-bit) instruction.
    function automatic logic [2:0] pc_step(input logic compressed);
        return compressed ? 3'(PC_STEP_16) : 3'(PC_STEP_32);
    endfunction

endpackage

// File: rtl/rv32_pc_unit.sv
// Program counter: load (bit0 forced to 0) takes priority over a 2/4-byte increment.
module rv32_pc_unit
    import rv32_pkg::*;
#(
    parameter int unsigned      XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT[XLEN-1:0]
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_val_i,
    input  logic            inc_i,
    input  logic            compressed_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Next PC selection.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = {load_val_i[XLEN-1:1], 1'b0};
        end else if (inc_i) begin
            pc_d = pc_q + {{(XLEN-3){1'b0}}, pc_step(compressed_i)};
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= {RESET_PC[XLEN-1:1], 1'b0};
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/rv32_regfile_pc_multi.sv
// Integer register file with NUM_READ registered write-first read ports, a hardware
// clear sequencer for the non-resettable storage, and the program counter.
module rv32_regfile_pc_multi
    import rv32_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     REG_BITS = 5,
    parameter int unsigned     NUM_READ = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0]
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    output logic                         busy_o,
    input  logic                         write_i,
    input  logic [REG_BITS-1:0]          rd_addr_i,
    input  logic [XLEN-1:0]              data_i,
    input  logic [NUM_READ*REG_BITS-1:0] rs_addr_i,
    output logic [NUM_READ*XLEN-1:0]     rs_o,
    input  logic                         write_pc_i,
    input  logic [XLEN-1:0]              data_pc_i,
    input  logic                         increment_pc_i,
    input  logic                         compressed_i,
    output logic [XLEN-1:0]              pc_o
);

    localparam int unsigned         NUM_REGS = 1 << REG_BITS;
    localparam logic [REG_BITS-1:0] CNT_LAST = {REG_BITS{1'b1}};
    localparam logic [REG_BITS-1:0] CNT_ONE  = {{(REG_BITS-1){1'b0}}, 1'b1};
    localparam logic [REG_BITS-1:0] ADDR_X0  = {REG_BITS{1'b0}};

    logic [0:0]          state_q;
    logic [0:0]          state_d;
    logic [REG_BITS-1:0] cnt_q;
    logic [REG_BITS-1:0] cnt_d;
    logic [XLEN-1:0]     mem_q [NUM_REGS];
    logic                busy_s;
    logic                wr_en_s;
    logic                flush_s;

    assign busy_s  = (state_q == ST_CLEAR);
    assign wr_en_s = write_i && !busy_s && (rd_addr_i != ADDR_X0);
    // A clear accepted this cycle already blanks the read ports on the next one.
    assign flush_s = busy_s || clear_i;
    assign busy_o  = busy_s;

    // Clear sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {REG_BITS{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = {REG_BITS{1'b0}};
            end
        endcase
    end

    // Clear sequencer state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_CLEAR;
            cnt_q   <= {REG_BITS{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array: RAM-style, zeroed by the sequencer rather than by reset.
    always_ff @(posedge clk_i) begin
        if (busy_s) begin
            mem_q[cnt_q] <= {XLEN{1'b0}};
        end else if (wr_en_s) begin
            mem_q[rd_addr_i] <= data_i;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [REG_BITS-1:0] addr_s;
        logic [XLEN-1:0]     rd_d;
        logic [XLEN-1:0]     rd_q;

        assign addr_s = rs_addr_i[k*REG_BITS +: REG_BITS];

        // Read data select with write-first bypass; x0 always reads zero.
        always_comb begin
            rd_d = {XLEN{1'b0}};
            if (flush_s || (addr_s == ADDR_X0)) begin
                rd_d = {XLEN{1'b0}};
            end else if (wr_en_s && (rd_addr_i == addr_s)) begin
                rd_d = data_i;
            end else begin
                rd_d = mem_q[addr_s];
            end
        end

        // Registered read port.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_q <= {XLEN{1'b0}};
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rs_o[k*XLEN +: XLEN] = rd_q;
    end

    rv32_pc_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (write_pc_i && !busy_s),
        .load_val_i   (data_pc_i),
        .inc_i        (increment_pc_i && !busy_s),
        .compressed_i (compressed_i),
        .pc_o         (pc_o)
    );

endmodule

// File: tb/tb_rv32_regfile_pc_multi.sv
// Scoreboard bench: the driver updates an array/counter reference model and queues the
// expected outputs; an independent monitor pops and compares after every rising edge.
module tb_rv32_regfile_pc_multi;

    localparam int          XLEN = 32;
    localparam int          RB   = 5;
    localparam int          NR   = 3;
    localparam int          NREG = 32;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear_i, busy_o, write_i, write_pc_i, increment_pc_i, compressed_i;
    logic [RB-1:0]     rd_addr_i;
    logic [XLEN-1:0]   data_i, data_pc_i, pc_o;
    logic [NR*RB-1:0]  rs_addr_i;
    logic [NR*XLEN-1:0] rs_o;

    rv32_regfile_pc_multi #(
        .XLEN(XLEN), .REG_BITS(RB), .NUM_READ(NR), .RESET_PC(RPC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .busy_o(busy_o),
        .write_i(write_i), .rd_addr_i(rd_addr_i), .data_i(data_i),
        .rs_addr_i(rs_addr_i), .rs_o(rs_o),
        .write_pc_i(write_pc_i), .data_pc_i(data_pc_i),
        .increment_pc_i(increment_pc_i), .compressed_i(compressed_i), .pc_o(pc_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              busy;
        logic [NR*32-1:0]  rs;
        logic [31:0]       pc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_reg [NREG];
    int          m_busy_left;
    logic [31:0] m_pc;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus at a falling edge, advance the model, queue expectation.
    task automatic step(input logic clr, input logic wr, input logic [4:0] rd,
                        input logic [31:0] d, input logic [14:0] rs, input logic wpc,
                        input logic [31:0] dpc, input logic inc, input logic cmp);
        exp_t e;
        logic busy_now;
        logic [4:0] a;
        clear_i = clr; write_i = wr; rd_addr_i = rd; data_i = d; rs_addr_i = rs;
        write_pc_i = wpc; data_pc_i = dpc; increment_pc_i = inc; compressed_i = cmp;
        busy_now = (m_busy_left > 0);
        for (int k = 0; k < NR; k++) begin
            a = rs[k*5 +: 5];
            if (busy_now || clr || a == 5'd0) e.rs[k*32 +: 32] = 32'd0;
            else if (wr && rd == a)           e.rs[k*32 +: 32] = d;
            else                              e.rs[k*32 +: 32] = m_reg[a];
        end
        if (busy_now) begin
            m_reg[NREG - m_busy_left] = 32'd0;
            m_busy_left--;
        end else begin
            if (clr) m_busy_left = NREG;
            if (wr && rd != 5'd0) m_reg[rd] = d;
            if (wpc)      m_pc = {dpc[31:1], 1'b0};
            else if (inc) m_pc = m_pc + (cmp ? 32'd2 : 32'd4);
        end
        e.busy = (m_busy_left > 0);
        e.pc   = m_pc;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 15'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic sweep_reads();
        for (int i = 0; i < NREG; i += NR)
            step(1'b0, 1'b0, 5'd0, 32'd0,
                 {5'((i + 2) % NREG), 5'((i + 1) % NREG), 5'(i)}, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse starting at a falling edge; outputs must react at once.
    task automatic do_reset();
        rst_n = 1'b0;
        m_busy_left = NREG;
        m_pc = RPC;
        #1;
        chk("rst_pc", pc_o, RPC);
        chk("rst_busy", {31'd0, busy_o}, 32'd1);
        for (int k = 0; k < NR; k++) chk("rst_rs", rs_o[k*32 +: 32], 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare every queued expectation just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("busy", {31'd0, busy_o}, {31'd0, e.busy});
                chk("pc", pc_o, e.pc);
                for (int k = 0; k < NR; k++) chk($sformatf("rs%0d", k), rs_o[k*32 +: 32], e.rs[k*32 +: 32]);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clear_i = 1'b0; write_i = 1'b0; rd_addr_i = 5'd0; data_i = 32'd0; rs_addr_i = 15'd0;
        write_pc_i = 1'b0; data_pc_i = 32'd0; increment_pc_i = 1'b0; compressed_i = 1'b0;
        for (int i = 0; i < NREG; i++) m_reg[i] = 32'hxxxx_xxxx;
        @(negedge clk);
        do_reset();

        // Clear after reset, then every address must read zero.
        idle(NREG);
        sweep_reads();

        // Basic write/read and x0 handling.
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 15'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'd0, {5'd0, 5'd0, 5'd5}, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd0, 32'h0000_1234, {5'd0, 5'd0, 5'd0}, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'd0, {5'd0, 5'd5, 5'd0}, 1'b0, 32'd0, 1'b0, 1'b0);

        // Same-cycle bypass on all ports.
        step(1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, {5'd7, 5'd7, 5'd7}, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'd0, {5'd7, 5'd7, 5'd7}, 1'b0, 32'd0, 1'b0, 1'b0);

        // PC: increments, compressed step, load priority, wrap.
        step(1'b0, 1'b0, 5'd0, 32'd0, 15'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 15'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 15'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 15'd0, 1'b1, 32'h0000_0101, 1'b1, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 15'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 15'd0, 1'b0, 32'd0, 1'b1, 1'b0);

        // Fill x1..x31, clear with ignored traffic during busy, then sweep.
        for (int i = 1; i < NREG; i++)
            step(1'b0, 1'b1, 5'(i), $urandom() | 32'h1, 15'($urandom()), 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 15'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < NREG; i++)
            step(1'($urandom()), 1'b1, 5'($urandom()), $urandom(), 15'($urandom()),
                 1'($urandom()), $urandom(), 1'b1, 1'($urandom()));
        sweep_reads();

        // Reset in the middle of a clear sequence.
        step(1'b0, 1'b1, 5'd9, 32'h0BAD_F00D, 15'd0, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 15'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        idle(10);
        do_reset();
        idle(NREG);
        sweep_reads();

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 59) == 0), 1'($urandom()), 5'($urandom()), $urandom(),
                 15'($urandom()), ($urandom_range(0, 7) == 0), $urandom(),
                 1'($urandom()), 1'($urandom()));

        idle(1);
        @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
